// File: rtl/rr_pop_scheduler_if.sv
// Pop/read-tag bundle between the scheduler, the input FIFO bank
// and the output stage.
interface rr_pop_scheduler_if #(
    parameter int NQ = 4
);
    logic [NQ-1:0]         empty;
    logic                  almost_full;
    logic [NQ-1:0]         pop;
    logic                  valid;
    logic [$clog2(NQ)-1:0] pop_id;

    modport master (
        input  empty,
        input  almost_full,
        output pop,
        output valid,
        output pop_id
    );

    modport slave (
        output empty,
        output almost_full,
        input  pop,
        input  valid,
        input  pop_id
    );
endinterface

// File: rtl/rr_pop_scheduler.sv
// Weighted round-robin pop scheduler for the four input FIFOs.
// One grant at a time, up to a weight-sized burst, one bubble between grants.
module rr_pop_scheduler #(
    parameter int NQ       = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    rr_pop_scheduler_if.master     bus,
    input  logic [NQ*WEIGHT_W-1:0] weights,
    output logic [1:0]             grant,
    output logic                   busy
);
    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

    state_t              state, state_n;
    logic [1:0]          ptr, ptr_n;
    logic [1:0]          grant_n;
    logic [1:0]          sel, idx;
    logic                found;
    logic [WEIGHT_W-1:0] credit, credit_n;
    logic [WEIGHT_W-1:0] wsel;

    // First non-empty FIFO at or after ptr, wrapping mod 4
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && !bus.empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign wsel = weights[int'(sel)*WEIGHT_W +: WEIGHT_W];
    assign busy = (state == SERVE);

    always_comb begin
        bus.pop = '0;
        if (state == SERVE && !bus.empty[grant] && !bus.almost_full)
            bus.pop[grant] = 1'b1;
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant;
        credit_n = credit;
        unique case (state)
            IDLE: begin
                if (found && !bus.almost_full) begin
                    grant_n  = sel;
                    credit_n = (wsel == '0) ? ONE : wsel;
                    state_n  = SERVE;
                end
            end
            SERVE: begin
                // Empty wins over backpressure: leftover credit is forfeited
                if (bus.empty[grant]) begin
                    ptr_n   = grant + 2'd1;
                    state_n = IDLE;
                end else if (!bus.almost_full) begin
                    credit_n = credit - ONE;
                    if (credit == ONE) begin
                        ptr_n   = grant + 2'd1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            credit     <= '0;
            bus.valid  <= 1'b0;
            bus.pop_id <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant     <= grant_n;
            credit    <= credit_n;
            bus.valid <= |bus.pop;
            if (|bus.pop)
                bus.pop_id <= grant;
        end
    end
endmodule

// File: tb/tb_rr_pop_scheduler.sv
// Directed bench for rr_pop_scheduler: per-cycle pop/busy tables,
// with valid/pop_id expected one cycle behind the expected pop.
module tb_rr_pop_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] weights = '0;
    logic [1:0]  grant;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

    rr_pop_scheduler_if #(.NQ(4)) bus ();

    rr_pop_scheduler #(.NQ(4), .WEIGHT_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .weights (weights),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh2i(input logic [3:0] v);
        oh2i = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) oh2i = 2'(i);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] ep [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
                                4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        logic       eb [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [3:0] prev = '0;
        bus.empty = 4'b0000;
        bus.almost_full = 1'b0;
        weights = {3'd1, 3'd1, 3'd1, 3'd1};
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (bus.pop !== 4'b0000) begin
            fails++;
            $display("FAIL rst_pop got %b exp 0000", bus.pop);
        end
        tests++;
        if (bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid got %b exp 0", bus.valid);
        end
        tests++;
        if (bus.pop_id !== 2'd0) begin
            fails++;
            $display("FAIL rst_pop_id got %0d exp 0", bus.pop_id);
        end
        tests++;
        if (grant !== 2'd0) begin
            fails++;
            $display("FAIL rst_grant got %0d exp 0", grant);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy got %b exp 0", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests++;
            if (bus.pop !== ep[c]) begin
                fails++;
                $display("FAIL rr_pop c%0d got %b exp %b", c, bus.pop, ep[c]);
            end
            tests++;
            if (busy !== eb[c]) begin
                fails++;
                $display("FAIL rr_busy c%0d got %b exp %b", c, busy, eb[c]);
            end
            tests++;
            if (bus.valid !== (prev != 0)) begin
                fails++;
                $display("FAIL rr_valid c%0d got %b exp %b", c, bus.valid, prev != 0);
            end
            if (prev != 0) begin
                tests++;
                if (bus.pop_id !== oh2i(prev)) begin
                    fails++;
                    $display("FAIL rr_pop_id c%0d got %0d exp %0d", c, bus.pop_id, oh2i(prev));
                end
            end
            prev = ep[c];
            @(negedge clk);
        end
    endtask

    task automatic test_weighted();
        logic [3:0] ep [13] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4,
                                4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h0};
        logic       eb [13] = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0};
        logic [3:0] prev = '0;
        bus.empty = 4'b0000;
        bus.almost_full = 1'b0;
        weights = {3'd1, 3'd4, 3'd0, 3'd2};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            // Mid-burst weight change must not shorten FIFO2's burst
            if (c == 7) weights = {3'd1, 3'd1, 3'd1, 3'd1};
            #1;
            tests++;
            if (bus.pop !== ep[c]) begin
                fails++;
                $display("FAIL wt_pop c%0d got %b exp %b", c, bus.pop, ep[c]);
            end
            tests++;
            if (busy !== eb[c]) begin
                fails++;
                $display("FAIL wt_busy c%0d got %b exp %b", c, busy, eb[c]);
            end
            tests++;
            if (bus.valid !== (prev != 0)) begin
                fails++;
                $display("FAIL wt_valid c%0d got %b exp %b", c, bus.valid, prev != 0);
            end
            if (prev != 0) begin
                tests++;
                if (bus.pop_id !== oh2i(prev)) begin
                    fails++;
                    $display("FAIL wt_pop_id c%0d got %0d exp %0d", c, bus.pop_id, oh2i(prev));
                end
            end
            prev = ep[c];
            @(negedge clk);
        end
    endtask

    task automatic test_early_empty();
        logic [3:0] ep [9] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0,
                               4'h4, 4'h0, 4'h1, 4'h0};
        logic       eb [9] = '{0, 1, 1, 1, 0, 1, 0, 1, 0};
        logic [3:0] prev = '0;
        bus.empty = 4'b1001;
        bus.almost_full = 1'b0;
        weights = {3'd1, 3'd1, 3'd4, 3'd1};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            // FIFO1 drains after 2 words; FIFO0 fills so a wrong ptr shows up
            bus.empty = (c >= 3) ? 4'b1010 : 4'b1001;
            bus.almost_full = (c == 3);
            #1;
            tests++;
            if (bus.pop !== ep[c]) begin
                fails++;
                $display("FAIL ee_pop c%0d got %b exp %b", c, bus.pop, ep[c]);
            end
            tests++;
            if (busy !== eb[c]) begin
                fails++;
                $display("FAIL ee_busy c%0d got %b exp %b", c, busy, eb[c]);
            end
            tests++;
            if (bus.valid !== (prev != 0)) begin
                fails++;
                $display("FAIL ee_valid c%0d got %b exp %b", c, bus.valid, prev != 0);
            end
            if (c == 5) begin
                tests++;
                if (grant !== 2'd2) begin
                    fails++;
                    $display("FAIL ee_grant c%0d got %0d exp 2", c, grant);
                end
            end
            prev = ep[c];
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ep [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0,
                                4'h0, 4'h1, 4'h1, 4'h0, 4'h2};
        logic       eb [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic [3:0] prev = '0;
        bus.empty = 4'b0000;
        bus.almost_full = 1'b0;
        weights = {3'd1, 3'd1, 3'd1, 3'd4};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.almost_full = (c >= 3 && c <= 5);
            #1;
            tests++;
            if (bus.pop !== ep[c]) begin
                fails++;
                $display("FAIL bp_pop c%0d got %b exp %b", c, bus.pop, ep[c]);
            end
            tests++;
            if (busy !== eb[c]) begin
                fails++;
                $display("FAIL bp_busy c%0d got %b exp %b", c, busy, eb[c]);
            end
            tests++;
            if (bus.valid !== (prev != 0)) begin
                fails++;
                $display("FAIL bp_valid c%0d got %b exp %b", c, bus.valid, prev != 0);
            end
            if (c >= 3 && c <= 5) begin
                tests++;
                if (grant !== 2'd0) begin
                    fails++;
                    $display("FAIL bp_grant c%0d got %0d exp 0", c, grant);
                end
            end
            prev = ep[c];
            @(negedge clk);
        end
    endtask

    task automatic test_sparse_reset();
        logic [3:0] ep [7] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
        logic       eb [7] = '{0, 1, 1, 1, 0, 1, 1};
        bus.empty = 4'b1011;
        bus.almost_full = 1'b0;
        weights = {3'd1, 3'd3, 3'd1, 3'd1};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            #1;
            tests++;
            if (bus.pop !== ep[c]) begin
                fails++;
                $display("FAIL sp_pop c%0d got %b exp %b", c, bus.pop, ep[c]);
            end
            tests++;
            if (busy !== eb[c]) begin
                fails++;
                $display("FAIL sp_busy c%0d got %b exp %b", c, busy, eb[c]);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (bus.pop !== 4'b0000) begin
            fails++;
            $display("FAIL mr_pop got %b exp 0000", bus.pop);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mr_busy got %b exp 0", busy);
        end
        @(negedge clk);
        tests++;
        if (bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL mr_valid got %b exp 0", bus.valid);
        end
        tests++;
        if (bus.pop_id !== 2'd0) begin
            fails++;
            $display("FAIL mr_pop_id got %0d exp 0", bus.pop_id);
        end
        bus.empty = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (bus.pop !== 4'b0001) begin
            fails++;
            $display("FAIL mr_restart_pop got %b exp 0001", bus.pop);
        end
        @(negedge clk);
        tests++;
        if (bus.valid !== 1'b1 || bus.pop_id !== 2'd0) begin
            fails++;
            $display("FAIL mr_restart_tag got v=%b id=%0d exp v=1 id=0", bus.valid, bus.pop_id);
        end
    endtask

    initial begin
        bus.empty = 4'b0000;
        bus.almost_full = 1'b0;
        test_reset();
        test_weighted();
        test_early_empty();
        test_backpressure();
        test_sparse_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_pop_scheduler.md
# rr_pop_scheduler

Weighted round-robin pop scheduler for the four input FIFOs of the switch datapath. Watches the FIFOs' `empty` flags and a downstream `almost_full` backpressure flag, and grants one FIFO at a time for up to a programmable number of pops. It drives the per-FIFO pop strobes, and issues the registered `valid` and `pop_id` that tag the word leaving the shared read bus one cycle later. It sits between the input FIFO bank and the output stage, and replaces hard-wired pop sequencing.

## Interface
- `NQ`, default 4: number of input FIFOs. Fixed at 4 in this revision.
- `WEIGHT_W`, default 3: width of each per-FIFO weight field.
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `empty`, input, 4: empty flag of FIFO i on bit i. 1 means empty.
- `almost_full`, input, 1: downstream backpressure. 1 blocks all pops.
- `weights`, input, 12: pop quantum for FIFO i on bits [3i+2:3i]. The value 0 is treated as 1.
- `pop`, output, 4: one-hot pop strobe to the FIFOs, combinational from state and inputs.
- `pop_id`, output, 2: index of the FIFO popped in the previous cycle. Registered.
- `valid`, output, 1: read bus carries a word popped in the previous cycle. Registered.
- `grant`, output, 2: FIFO currently owning the bus. Registered.
- `busy`, output, 1: 1 while the FSM is in SERVE.

## Operation
- Registers: `state` (IDLE/SERVE), `ptr[1:0]` (search start), `grant[1:0]`, `credit[WEIGHT_W-1:0]`, `valid`, `pop_id`.
- IDLE:
  - Search FIFOs in order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) and take the first index with `empty[i]==0`.
  - If a FIFO is found and `almost_full==0`:
    - `grant` <= i
    - `credit` <= max(`weights[i]`, 1)
    - `state` <= SERVE
  - Otherwise stay in IDLE. `ptr` is unchanged.
- SERVE, pop condition: `pop[grant]` = (state==SERVE) & !`empty[grant]` & !`almost_full`. All other `pop` bits are 0.
- SERVE, pop cycle: `credit` decrements by 1. If the decremented credit is 0, then `ptr` <= `grant`+1 (mod 4) and `state` <= IDLE.
- SERVE, empty: if `empty[grant]==1`, no pop occurs and the remaining credit is forfeited. `ptr` <= `grant`+1 and `state` <= IDLE in the same cycle.
- SERVE, backpressure: if `almost_full==1` and `empty[grant]==0`, no pop occurs. `credit`, `grant` and `state` hold.
- Empty has priority over backpressure: if both are 1, the release path is taken.
- `weights` is sampled only on the IDLE→SERVE transition. Changes during SERVE do not affect the current grant.
- Output tagging: `valid` <= |`pop` and `pop_id` <= `grant` when |`pop`. `pop_id` holds its last value when no pop occurs.
- Fairness: a FIFO that releases is searched last on the next arbitration.

## Timing
- Reset (asynchronous, `reset`==0) forces:
  - `state`=IDLE, `ptr`=0, `grant`=0, `credit`=0
  - `valid`=0, `pop_id`=0, `busy`=0
  - `pop`=0000, combinationally, because state is IDLE
- Reset asserted mid-SERVE aborts the grant immediately. No pop is issued while `reset`==0.
- Arbitration latency: one IDLE cycle (bubble) between grants. The first pop occurs in the cycle after the FIFO is found non-empty.
- Read latency: `valid`/`pop_id` rise in the cycle following the `pop` cycle (the FIFO read is registered).
- Maximum throughput per grant: `weights[i]` consecutive pops, followed by one bubble.
- `almost_full` is honoured combinationally in the same cycle; the downstream must assert it at least one word early.
- All FIFOs empty: the FSM stays in IDLE, with `pop`=0 and `valid`=0.

## Test plan
- Reset state:
  - Stimulus: hold `reset`=0 with `empty`=0000.
  - Required: `pop`=0000, `valid`=0, `pop_id`=00, `grant`=00, `busy`=0.
  - Then release reset with `weights`=all 1. Required: grant order 0,1,2,3,0, each grant giving one pop then one bubble cycle.
- Weighted bursts:
  - Stimulus: `weights`={3'd1,3'd4,3'd0,3'd2} for FIFO3..FIFO0, all FIFOs non-empty.
  - Required pop counts per grant: FIFO0=2, FIFO1=1 (weight 0 treated as 1), FIFO2=4, FIFO3=1.
  - Required: `pop_id` sequence 0,0,1,2,2,2,2,3, each value lagging its `pop` by one cycle.
- Early empty:
  - Stimulus: FIFO1 with weight 4 holding 2 words; FIFO2 non-empty.
  - Required: 2 pops from FIFO1, release on the cycle `empty[1]` rises, then the next grant goes to FIFO2 (`ptr`=2).
- Backpressure:
  - Stimulus: assert `almost_full` for 3 cycles in the middle of a weight-4 burst after 2 pops.
  - Required: `pop`=0000 for those 3 cycles, `credit` held at 2, `grant` unchanged. The remaining 2 pops follow once `almost_full` drops.
- Sparse requests and mid-burst reset:
  - Stimulus: `empty`=1011 (only FIFO2 non-empty).
  - Required: repeated grants to FIFO2 only, with no grant to any empty FIFO.
  - Stimulus: then pulse `reset`=0 during a burst.
  - Required: `pop`=0000 immediately, `valid`=0 on the next edge, and after release the search restarts from FIFO0.
